// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
//
// Purpose:
//   Buffers one tile of operand columns (up to DEPTH columns, LANES elements
//   each) and streams them into the rows of a systolic array with the classic
//   diagonal skew: lane i presents column (t - i) at step t, so row i of the
//   array sees its operands exactly i steps after row 0. Operands are FP32 bit
//   patterns and pass through untouched.
//
//   Flow: IDLE/LOAD accept columns -> STREAM issues count+LANES-1 steps gated
//   by feed_en -> FLUSH clears the valids and pulses done -> IDLE.
//
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst       : asynchronous active-low reset
//   in_valid  : in_data / in_last valid this cycle
//   in_ready  : feeder accepts a column this cycle
//   in_data   : one tile column, slice i is the element for lane i
//   in_last   : the accompanying column closes the tile
//   feed_en   : array advance enable; low stalls streaming with outputs held
//   out_data  : registered skewed operands, slice i drives PE row i
//   out_valid : per-lane operand valid
//   busy      : high whenever the feeder is not IDLE
//   done      : one-cycle pulse at tile completion
//
// Configuration macro:
//   SYSTOLIC_FEEDER_ZERO_PAD_EN : when defined, every lane that is not valid
//   after an update drives 0 (FP32 +0.0). When undefined, invalid lanes keep
//   their last driven value and only out_valid marks validity.
// -----------------------------------------------------------------------------
module systolic_feeder #(
  parameter int LANES  = 4,
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic                      in_last,
  input  logic                      feed_en,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [LANES-1:0]          out_valid,
  output logic                      busy,
  output logic                      done
);

  // Column counter must reach DEPTH; step counter must reach count+LANES
  // (the comparison below adds 2 on the step side to avoid a negative term).
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(DEPTH + LANES + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_FLUSH  = 2'd3
  } state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_count;
  logic [TW-1:0]             r_t;
  logic [LANES*DATA_W-1:0]   r_out_data;
  logic [LANES-1:0]          r_out_valid;
  logic                      r_done;

  // Tile buffer: one full column per entry, no reset needed since only
  // entries below r_count are ever read.
  logic [LANES*DATA_W-1:0]   r_buf [DEPTH];

  logic                      w_accept;
  logic                      w_last_step;
  logic [LANES-1:0]          w_lane_valid;
  logic [LANES*DATA_W-1:0]   w_next_data;

  assign in_ready = ((r_state == S_IDLE) || (r_state == S_LOAD)) &&
                    (r_count < CW'(DEPTH));
  assign w_accept = in_valid && in_ready;

  // The step issuing t = count+LANES-2 is the final STREAM step.
  assign w_last_step = ((r_t + TW'(2)) == (TW'(r_count) + TW'(LANES)));

  // Per-lane skew: lane gi reads column (t - gi) while that index lies inside
  // the loaded tile.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [TW-1:0]     w_idx;
      logic              w_hit;
      logic [DATA_W-1:0] w_rd;

      assign w_idx = r_t - TW'(gi);
      assign w_hit = (r_t >= TW'(gi)) && (w_idx < TW'(r_count));
      assign w_rd  = r_buf[w_idx[AW-1:0]][gi*DATA_W +: DATA_W];
      assign w_lane_valid[gi] = w_hit;
`ifdef SYSTOLIC_FEEDER_ZERO_PAD_EN
      assign w_next_data[gi*DATA_W +: DATA_W] = w_hit ? w_rd : '0;
`else
      assign w_next_data[gi*DATA_W +: DATA_W] =
        w_hit ? w_rd : r_out_data[gi*DATA_W +: DATA_W];
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_count[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_t         <= '0;
      r_out_data  <= '0;
      r_out_valid <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_LOAD: begin
          if (w_accept) begin
            r_count <= r_count + CW'(1);
            // Close the tile on in_last or when the buffer just filled.
            if (in_last || (r_count == CW'(DEPTH - 1))) begin
              r_state <= S_STREAM;
              r_t     <= '0;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_STREAM: begin
          if (feed_en) begin
            r_out_valid <= w_lane_valid;
            r_out_data  <= w_next_data;
            r_t         <= r_t + TW'(1);
            if (w_last_step) begin
              r_state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (feed_en) begin
            r_out_valid <= '0;
`ifdef SYSTOLIC_FEEDER_ZERO_PAD_EN
            r_out_data  <= '0;
`endif
            r_done      <= 1'b1;
            r_count     <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign done      = r_done;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_systolic_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder
//
// Directed bench for systolic_feeder (LANES=4, DEPTH=8, DATA_W=32). Loading a
// tile pushes the expected per-step lane valids/data plus the flush/done step
// into a scoreboard queue; every feed_en edge pops one entry and compares.
// Covers the two-column example, an auto-closed 8-column tile, a single
// column, a three-cycle feed_en stall and a reset in the middle of streaming.
// Builds with or without SYSTOLIC_FEEDER_ZERO_PAD_EN.
// -----------------------------------------------------------------------------
module tb_systolic_feeder;

  localparam int LANES  = 4;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int W      = LANES * DATA_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             feed_en = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic             in_ready;
  logic [W-1:0]     out_data;
  logic [LANES-1:0] out_valid;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic             dn;
    logic [LANES-1:0] v;
    logic [W-1:0]     d;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] cols[DEPTH];
  logic [W-1:0] model_d = '0;

  always #5 clk = ~clk;

  systolic_feeder #(.LANES(LANES), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .feed_en   (feed_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mkcol(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  // Expected stream for an n-column tile: lane i valid at step s when
  // 0 <= s-i < n, carrying element i of column s-i.
  task automatic build_expect(input int n);
    exp_t e;
    for (int s = 0; s < n + LANES - 1; s++) begin
      e.dn = 1'b0;
      e.v  = '0;
      for (int i = 0; i < LANES; i++) begin
        if (s >= i && (s - i) < n) begin
          e.v[i] = 1'b1;
          model_d[i*DATA_W +: DATA_W] = cols[s-i][i*DATA_W +: DATA_W];
        end else begin
`ifdef SYSTOLIC_FEEDER_ZERO_PAD_EN
          model_d[i*DATA_W +: DATA_W] = '0;
`endif
        end
      end
      e.d = model_d;
      sb.push_back(e);
    end
    e.dn = 1'b1;
    e.v  = '0;
`ifdef SYSTOLIC_FEEDER_ZERO_PAD_EN
    model_d = '0;
`endif
    e.d = model_d;
    sb.push_back(e);
  endtask

  task automatic load_tile(input int n, input bit use_last, input bit hold_valid);
    for (int c = 0; c < n; c++) begin
      in_valid = 1'b1;
      in_data  = cols[c];
      in_last  = use_last && (c == n - 1);
      check($sformatf("in_ready_beat%0d", c), W'(in_ready), W'(1'b1));
      check($sformatf("valid_idle_beat%0d", c), W'(out_valid), W'(0));
      tick();
      $display("load beat %0d data=%h last=%b", c, cols[c], in_last);
    end
    in_last = 1'b0;
    if (hold_valid) begin
      in_data = {LANES{32'hDEADBEEF}};
    end else begin
      in_valid = 1'b0;
    end
    check("in_ready_after_load", W'(in_ready), W'(1'b0));
    check("busy_after_load", W'(busy), W'(1'b1));
    build_expect(n);
  endtask

  task automatic run_stream(input int stall_at, input int reset_at);
    exp_t e;
    exp_t last;
    int   step = 0;
    last = '0;
    while (sb.size() > 0) begin
      if (step == stall_at) begin
        feed_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          $display("stall cycle %0d valid=%b data=%h", k, out_valid, out_data);
          check("stall_valid", W'(out_valid), W'(last.v));
          check("stall_data", out_data, last.d);
          check("stall_done", W'(done), W'(1'b0));
        end
        feed_en = 1'b1;
      end
      if (step == reset_at) begin
        #2 rst = 1'b0;
        #1;
        $display("async reset at step %0d", step);
        check("rst_valid", W'(out_valid), W'(0));
        check("rst_data", out_data, W'(0));
        check("rst_busy", W'(busy), W'(1'b0));
        check("rst_done", W'(done), W'(1'b0));
        sb.delete();
        model_d = '0;
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_in_ready", W'(in_ready), W'(1'b1));
        for (int k = 0; k < 4; k++) begin
          check("post_rst_no_done", W'(done), W'(1'b0));
          tick();
        end
        return;
      end
      e = sb.pop_front();
      if (e.dn) in_valid = 1'b0;
      check("stream_in_ready", W'(in_ready), W'(1'b0));
      tick();
      $display("step %0d valid=%b data=%h done=%b", step, out_valid, out_data, done);
      check($sformatf("valid_s%0d", step), W'(out_valid), W'(e.v));
      check($sformatf("data_s%0d", step), out_data, e.d);
      check($sformatf("done_s%0d", step), W'(done), W'(e.dn));
      check($sformatf("busy_s%0d", step), W'(busy), W'(!e.dn));
      last = e;
      step++;
    end
    tick();
    check("done_one_cycle", W'(done), W'(1'b0));
  endtask

  initial begin
    // Reset state
    feed_en = 1'b1;
    tick();
    tick();
    check("reset_valid", W'(out_valid), W'(0));
    check("reset_data", out_data, W'(0));
    check("reset_busy", W'(busy), W'(1'b0));
    check("reset_done", W'(done), W'(1'b0));
    rst = 1'b1;
    tick();
    check("first_in_ready", W'(in_ready), W'(1'b1));

    // Two-column tile from the worked example
    cols[0] = mkcol(32'h40000000, 32'h40800000, 32'h41000000, 32'h41800000);
    cols[1] = mkcol(32'h41000000, 32'h41000000, 32'h41000000, 32'h41000000);
    load_tile(2, 1'b1, 1'b0);
    run_stream(-1, -1);

    // Full tile without in_last: auto-close after the 8th beat; in_valid is
    // held high with junk during streaming and must not be consumed.
    for (int c = 0; c < DEPTH; c++) begin
      cols[c] = mkcol(32'h3F800000 + 32'(c * 16), 32'h3F800001 + 32'(c * 16),
                      32'h3F800002 + 32'(c * 16), 32'h3F800003 + 32'(c * 16));
    end
    load_tile(DEPTH, 1'b0, 1'b1);
    run_stream(-1, -1);

    // Single-column tile
    cols[0] = mkcol(32'hC0000000, 32'hC0400000, 32'hC0800000, 32'hC0A00000);
    load_tile(1, 1'b1, 1'b0);
    run_stream(-1, -1);

    // feed_en stall of three cycles at step 2
    cols[0] = mkcol(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    cols[1] = mkcol(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888);
    cols[2] = mkcol(32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC);
    load_tile(3, 1'b1, 1'b0);
    run_stream(2, -1);

    // Reset at step 3 discards the tile; the next tile streams cleanly
    cols[0] = mkcol(32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404);
    cols[1] = mkcol(32'h05050505, 32'h06060606, 32'h07070707, 32'h08080808);
    cols[2] = mkcol(32'h09090909, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C);
    cols[3] = mkcol(32'h0D0D0D0D, 32'h0E0E0E0E, 32'h0F0F0F0F, 32'h10101010);
    load_tile(4, 1'b1, 1'b0);
    run_stream(-1, 3);
    cols[0] = mkcol(32'h3E800000, 32'h3F000000, 32'h3F400000, 32'h3F800000);
    cols[1] = mkcol(32'hBE800000, 32'hBF000000, 32'hBF400000, 32'hBF800000);
    cols[2] = mkcol(32'h7F7FFFFF, 32'h00800000, 32'h80000000, 32'h7F800000);
    load_tile(3, 1'b1, 1'b0);
    run_stream(-1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter LANES, default 4: number of PE rows fed, one operand lane per row.
REQ-002 Parameter DEPTH, default 8: maximum columns (K dimension) buffered per tile.
REQ-003 Parameter DATA_W, default 32: operand width, FP32 bit pattern, passed through unmodified.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
REQ-006 Port in_valid, input, 1: in_data/in_last valid this cycle.
REQ-007 Port in_ready, output, 1: feeder accepts a column this cycle.
REQ-008 Port in_data, input, LANES*DATA_W: one tile column; slice i is the element for lane i.
REQ-009 Port in_last, input, 1: accompanying column is the final column of the tile.
REQ-010 Port feed_en, input, 1: array advance enable; low stalls streaming with outputs held.
REQ-011 Port out_data, output, LANES*DATA_W: registered skewed operands; slice i drives PE row i.
REQ-012 Port out_valid, output, LANES: per-lane operand valid.
REQ-013 Port busy, output, 1: high in any state other than IDLE.
REQ-014 Port done, output, 1: one-cycle pulse at tile completion.

Function
REQ-015 States: IDLE, LOAD, STREAM, FLUSH.
REQ-016 Column accepted on edge with in_valid && in_ready, written to buffer[count]; count increments.
REQ-017 in_ready = 1 in IDLE and LOAD while count < DEPTH; 0 in STREAM and FLUSH.
REQ-018 IDLE -> LOAD on accepted column without in_last.
REQ-019 IDLE or LOAD -> STREAM on accepted column with in_last, or when count reaches DEPTH (auto-close, in_last not required); step counter t cleared to 0.
REQ-020 In STREAM, on each edge with feed_en=1: for each lane i, if t >= i and t-i < count, out_data[i] <= buffer[t-i] and out_valid[i] <= 1, else out_valid[i] <= 0; then t increments.
REQ-021 Latency: lane 0 presents column 0 on the first feed_en edge after entering STREAM; lane i lags lane 0 by exactly i steps.
REQ-022 STREAM spans count+LANES-1 feed_en edges; the edge issuing t = count+LANES-2 moves state to FLUSH.
REQ-023 FLUSH: on next edge with feed_en=1, out_valid <= 0, done <= 1 for one cycle, count <= 0, state -> IDLE.
REQ-024 feed_en=0 in STREAM/FLUSH: out_data, out_valid, t, state all hold.
REQ-025 feed_en is ignored in IDLE and LOAD; out_valid stays 0 there.
REQ-026 in_valid while in_ready=0 is not consumed; upstream holds data.
REQ-027 count = 1 (in_last on first beat) is legal and streams LANES edges.

Reset
REQ-028 rst low asynchronously forces IDLE, count=0, t=0, out_data=0, out_valid=0, done=0, busy=0.
REQ-029 Reset mid-LOAD/STREAM/FLUSH discards the tile; no done pulse follows.
REQ-030 in_ready = 1 on the first edge after rst deasserts.

Configuration
REQ-031 Macro SYSTOLIC_FEEDER_ZERO_PAD_EN defined: any lane with out_valid[i]=0 after an update drives out_data[i] = 0 (FP32 +0.0).
REQ-032 Macro undefined: invalid lanes hold their last driven out_data value; only out_valid indicates validity.

Verification
REQ-033 LANES=4, DEPTH=8; load col0={40000000,40800000,41000000,41800000}, col1 with in_last={41000000 x4}; feed_en=1 -> 5 STREAM edges, lane3 valid at steps 3,4 with 41800000 then 41000000; done pulses after FLUSH edge.
REQ-034 Load 8 columns, no in_last -> in_ready drops after 8th beat, STREAM begins, 11 STREAM edges, then done.
REQ-035 Single column with in_last -> each lane i valid exactly at step i, 4 STREAM edges.
REQ-036 Drop feed_en for 3 cycles at step 2 -> out_data/out_valid frozen 3 cycles, sequence resumes unchanged, total feed_en edges unchanged.
REQ-037 Assert rst at step 3 -> outputs 0 immediately, no done, next tile loads and streams correctly.
REQ-038 Build with and without SYSTOLIC_FEEDER_ZERO_PAD_EN -> invalid lanes read 00000000 vs. previous value respectively.
